// File: rtl/ramsp_ext.sv
// Single-port RAM with per-lane write mask, selectable read-during-write
// behaviour, an optional output register and a self-clearing init sequencer.
module ramsp_ext #(
    parameter int unsigned    DW      = 16,
    parameter int unsigned    AW      = 10,
    parameter int unsigned    BW      = 8,
    parameter int unsigned    RDMODE  = 0,
    parameter int unsigned    OREG    = 0,
    parameter logic [DW-1:0]  INITVAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [DW/BW-1:0]     wmask,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dout,
    output logic                 dvalid,
    output logic                 busy
);

    localparam int unsigned NL    = DW / BW;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     ptr;

    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     rd_old;
    logic [DW-1:0]     merged;

    logic              acc;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;

    logic [DW-1:0]     d1;
    logic              v1;

    // State register; busy is kept as its own flop mirroring the INIT state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_INIT);
        end
    end

    // Next-state: leave INIT once the last word has been written
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (ptr == AW'(DEPTH - 1)) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_INIT;
        endcase
    end

    // Output decode: memory write port is owned by the sequencer during INIT
    always_comb begin
        acc       = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = merged;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr;
                    mem_wdata = INITVAL;
                end
                S_READY: begin
                    acc    = en;
                    mem_we = en & we & (|wmask);
                end
                default: ;
            endcase
        end
    end

    // Init pointer walks the whole array once per INIT pass
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == S_INIT) begin
            ptr <= ptr + AW'(1);
        end
    end

    assign rd_old = mem[addr];

    // Lane merge: masked lanes from din, others from the stored word
    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign merged[g*BW +: BW] = wmask[g] ? din[g*BW +: BW] : rd_old[g*BW +: BW];
    end

    // Storage array; never reset, only cleared by the sequencer
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // First read stage; no-change mode suppresses updates on writes
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else if (acc && !(we && (RDMODE == 2))) begin
            d1 <= (we && (RDMODE == 1)) ? merged : rd_old;
            v1 <= 1'b1;
        end else begin
            v1 <= 1'b0;
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] d2;
        logic          v2;

        // Optional second stage carries data and valid together
        always_ff @(posedge clk) begin
            if (rst) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                if (v1) d2 <= d1;
                v2 <= v1;
            end
        end

        assign dout   = d2;
        assign dvalid = v2;
    end else begin : g_noreg
        assign dout   = d1;
        assign dvalid = v1;
    end

endmodule
